// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// frame state encoding and the line levels used for idle, start and stop.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } stateT;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..M-1 and raises tick on the last cycle of each
// serial bit period, wrapping to 0 so the next period starts immediately.
module bit_timer #(
  parameter int M = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, N data bits LSB first, stop bit, each held
// for M clocks. All outputs are registered from next-state values.
module serial_tx
  import serial_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] DATA,
  input  logic         VALID,
  output logic         READY,
  output logic         Dout,
  output logic         BUSY,
  output logic         DONE
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  stateT         state, nextState;
  logic [N-1:0]  shreg, nextShreg;
  logic [BW-1:0] bitCnt, nextBitCnt;
  logic          tick;
  logic          accept;
  logic          nextReady, nextDout, nextBusy, nextDone;

  // The timer sits at zero while idle so START always gets a full period.
  bit_timer #(.M(M)) timer (
    .CLK  (CLK),
    .RST  (RST),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  assign accept = VALID && READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitCnt <= '0;
      READY  <= 1'b0;
      Dout   <= LINE_IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= nextState;
      shreg  <= nextShreg;
      bitCnt <= nextBitCnt;
      READY  <= nextReady;
      Dout   <= nextDout;
      BUSY   <= nextBusy;
      DONE   <= nextDone;
    end
  end

  always_comb begin
    nextState  = state;
    nextShreg  = shreg;
    nextBitCnt = bitCnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          nextState = ST_START;
          nextShreg = DATA;
        end
      end
      ST_START: begin
        if (tick) nextState = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          nextShreg = shreg >> 1;
          if (bitCnt == LAST_BIT) begin
            nextBitCnt = '0;
            nextState  = ST_STOP;
          end else begin
            nextBitCnt = bitCnt + BW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs are derived from where the FSM is going, then registered.
  always_comb begin
    nextReady = (nextState == ST_IDLE);
    nextBusy  = (nextState != ST_IDLE);
    nextDone  = (state == ST_STOP) && (nextState == ST_IDLE);
    case (nextState)
      ST_START: nextDout = LINE_START;
      ST_DATA:  nextDout = nextShreg[0];
      ST_STOP:  nextDout = LINE_STOP;
      default:  nextDout = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one M=2/N=4 instance for most scenarios and
// one M=1/N=8 instance for the single-cycle bit period.
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic [3:0] data;
  logic       valid, ready, dout, busy, done;
  logic [7:0] data1;
  logic       valid1, ready1, dout1, busy1, done1;

  int testsRun = 0;
  int testsFailed = 0;

  // Dout for cycles 1..12 after accepting 4'b1010, bit 0 = cycle 1.
  localparam logic [11:0] EXP31 = 12'b1111_0011_0000;
  // Dout for cycles 1..10 after accepting 8'h81 with M=1, bit 0 = cycle 1.
  localparam logic [9:0]  EXP35 = 10'b11_0000_0010;
  localparam logic [3:0]  WORDS32 [3] = '{4'h5, 4'hA, 4'h5};

  serial_tx #(.M(2), .N(4)) dut (
    .CLK(clk), .RST(rst), .DATA(data), .VALID(valid),
    .READY(ready), .Dout(dout), .BUSY(busy), .DONE(done)
  );

  serial_tx #(.M(1), .N(8)) dut1 (
    .CLK(clk), .RST(rst), .DATA(data1), .VALID(valid1),
    .READY(ready1), .Dout(dout1), .BUSY(busy1), .DONE(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d);
    valid = v;
    data  = d;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after acceptance for M=2, N=4.
  function automatic logic frameBit(input logic [3:0] w, input int k);
    if (k == 0) return 1'b1;
    if (k <= 2) return 1'b0;
    if (k <= 10) return w[(k - 3) / 2];
    return 1'b1;
  endfunction

  // Call right after the acceptance edge; ends one cycle past the DONE cycle.
  task automatic checkFrame(input string tag, input logic [3:0] w);
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("%s dout c%0d", tag, k), 32'(dout), 32'(frameBit(w, k)));
      checkOutput($sformatf("%s done c%0d", tag, k), 32'(done), 32'd0);
      nextCycle;
    end
    checkOutput({tag, " done c13"}, 32'(done), 32'd1);
    checkOutput({tag, " ready c13"}, 32'(ready), 32'd1);
    nextCycle;
    checkOutput({tag, " done c14"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0);
    valid1 = 1'b0;
    data1  = 8'h00;
    nextCycle;
    nextCycle;
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset dout", 32'(dout), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    nextCycle;

    // Idle line after reset: {dout,busy,done,ready} stays 1,0,0,1.
    for (int i = 0; i < 50; i++) begin
      checkOutput($sformatf("idle c%0d", i), 32'({dout, busy, done, ready}), 32'b1001);
      nextCycle;
    end

    applyStimulus(1'b1, 4'b1010);
    checkOutput("f1010 ready c0", 32'(ready), 32'd1);
    nextCycle;
    applyStimulus(1'b0, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("f1010 dout c%0d", k), 32'(dout), 32'(EXP31[k-1]));
      checkOutput($sformatf("f1010 busy c%0d", k), 32'(busy), 32'd1);
      checkOutput($sformatf("f1010 done c%0d", k), 32'(done), 32'd0);
      nextCycle;
    end
    checkOutput("f1010 done c13", 32'(done), 32'd1);
    checkOutput("f1010 ready c13", 32'(ready), 32'd1);
    checkOutput("f1010 busy c13", 32'(busy), 32'd0);
    nextCycle;
    checkOutput("f1010 done c14", 32'(done), 32'd0);

    // Back-to-back frames with VALID held high.
    applyStimulus(1'b1, WORDS32[0]);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k <= 12; k++) begin
        checkOutput($sformatf("b2b f%0d ready c%0d", f, k), 32'(ready), 32'(k == 0));
        checkOutput($sformatf("b2b f%0d dout c%0d", f, k), 32'(dout),
                    32'(frameBit(WORDS32[f], k)));
        checkOutput($sformatf("b2b f%0d done c%0d", f, k), 32'(done),
                    32'(k == 0 && f > 0));
        if (k == 1) data = (f < 2) ? WORDS32[f+1] : 4'h0;
        if (f == 2 && k == 12) valid = 1'b0;
        nextCycle;
      end
    end
    checkOutput("b2b final done", 32'(done), 32'd1);
    checkOutput("b2b final dout", 32'(dout), 32'd1);
    nextCycle;
    checkOutput("b2b idle busy", 32'(busy), 32'd0);

    applyStimulus(1'b1, 4'h0);
    nextCycle;
    applyStimulus(1'b0, 4'hF);
    checkFrame("hold0", 4'h0);

    // Abort a frame of 4'h6 with a reset pulse on cycle 6.
    applyStimulus(1'b1, 4'h6);
    nextCycle;
    applyStimulus(1'b0, 4'h6);
    for (int k = 1; k <= 6; k++) begin
      checkOutput($sformatf("abort dout c%0d", k), 32'(dout), 32'(frameBit(4'h6, k)));
      if (k < 6) nextCycle;
    end
    rst = 1'b1;
    nextCycle;
    checkOutput("abort dout", 32'(dout), 32'd1);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort ready in rst", 32'(ready), 32'd0);
    rst = 1'b0;
    nextCycle;
    checkOutput("abort ready after", 32'(ready), 32'd1);
    checkOutput("abort done after", 32'(done), 32'd0);
    applyStimulus(1'b1, 4'h9);
    nextCycle;
    applyStimulus(1'b0, 4'h0);
    checkFrame("after abort", 4'h9);

    // Reset wins over a simultaneous VALID.
    rst = 1'b1;
    applyStimulus(1'b1, 4'h3);
    nextCycle;
    checkOutput("prio busy", 32'(busy), 32'd0);
    checkOutput("prio ready", 32'(ready), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'h0);
    nextCycle;
    checkOutput("prio ready after", 32'(ready), 32'd1);
    checkOutput("prio busy after", 32'(busy), 32'd0);

    // M=1, N=8 instance.
    valid1 = 1'b1;
    data1  = 8'h81;
    checkOutput("m1 ready c0", 32'(ready1), 32'd1);
    nextCycle;
    valid1 = 1'b0;
    data1  = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      checkOutput($sformatf("m1 dout c%0d", k), 32'(dout1), 32'(EXP35[k-1]));
      checkOutput($sformatf("m1 done c%0d", k), 32'(done1), 32'd0);
      nextCycle;
    end
    checkOutput("m1 done c11", 32'(done1), 32'd1);
    checkOutput("m1 ready c11", 32'(ready1), 32'd1);
    nextCycle;
    checkOutput("m1 done c12", 32'(done1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
